// File: rtl/adc_emulator_multi_if.sv
// Sample-stream bundle between the ADC emulator and its consumer:
// runtime controls in, one strobed vector of per-channel samples out.
interface adc_emulator_multi_if #(
  parameter int NCHAN  = 4,
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10,
  parameter int PWIDTH = 8
);
  logic                           enable;
  logic [PWIDTH-1:0]              period;
  logic [AWIDTH-1:0]              phase_inc;
  logic [1:0]                     mode;
  logic                           dv_out;
  logic [NCHAN-1:0][DWIDTH-1:0]   d_out;
  logic [15:0]                    seq_out;

  modport master (
    input  enable, period, phase_inc, mode,
    output dv_out, d_out, seq_out
  );

  modport slave (
    output enable, period, phase_inc, mode,
    input  dv_out, d_out, seq_out
  );
endinterface

// File: rtl/adc_emulator_multi.sv
// Multi-channel ADC emulator: periodic strobe carrying NCHAN samples of a
// phase-offset sine, ramp, channel-ID or sequence-count pattern.
module adc_emulator_multi #(
  parameter int NCHAN       = 4,
  parameter int DWIDTH      = 18,
  parameter int AWIDTH      = 10,
  parameter int PWIDTH      = 8,
  parameter int CHAN_OFFSET = 200
) (
  input logic                  clk,
  input logic                  resetn,
  adc_emulator_multi_if.master bus
);
  localparam int  DEPTH = 1 << AWIDTH;
  localparam int  SHIFT = DWIDTH - AWIDTH;
  localparam real AMP   = (2.0 ** (DWIDTH - 1)) - 1.0;
  localparam real PI    = 3.14159265358979323846;

  function automatic logic signed [DWIDTH-1:0] round_away(input real v);
    real mag;
    int  r;
    mag = (v < 0.0) ? -v : v;
    r   = $rtoi(mag + 0.5);
    if (v < 0.0) r = -r;
    return DWIDTH'(r);
  endfunction

  function automatic logic signed [DWIDTH-1:0] sine_entry(input int i);
    return round_away(AMP * $sin(2.0 * PI * real'(i) / real'(DEPTH)));
  endfunction

  // Table is fully determined at elaboration; reads are combinational so the
  // sample lands in the same register stage as dv/seq.
  logic signed [DWIDTH-1:0] rom [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = sine_entry(i);
  end

  logic [PWIDTH-1:0]            cnt;
  logic [AWIDTH-1:0]            addr;
  logic [15:0]                  seq;
  logic [AWIDTH-1:0]            chan_addr [NCHAN];
  logic [NCHAN-1:0][DWIDTH-1:0] sample_next;
  logic                         fire;

  logic                         vld_p0;
  logic [NCHAN-1:0][DWIDTH-1:0] sample_p0;
  logic [15:0]                  seq_p0;

  assign fire = bus.enable && (cnt == '0);

  always_comb begin
    sample_next = '0;
    for (int c = 0; c < NCHAN; c++) begin
      chan_addr[c] = addr + AWIDTH'(c * CHAN_OFFSET);
      case (bus.mode)
        2'd0: sample_next[c] = rom[chan_addr[c]];
        2'd1: sample_next[c] = DWIDTH'(chan_addr[c]) << SHIFT;
        2'd2: sample_next[c] = DWIDTH'(c + 1);
        2'd3: sample_next[c] = DWIDTH'(32'(seq) + 32'(c));
      endcase
    end
  end

  // Stage p0: registered outputs, all three fields updated on the same edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      addr      <= '0;
      seq       <= '0;
      vld_p0    <= 1'b0;
      sample_p0 <= '0;
      seq_p0    <= '0;
    end else begin
      vld_p0 <= 1'b0;
      if (fire) begin
        cnt       <= bus.period;
        addr      <= addr + bus.phase_inc;
        seq       <= seq + 16'd1;
        vld_p0    <= 1'b1;
        sample_p0 <= sample_next;
        seq_p0    <= seq;
      end else if (bus.enable) begin
        cnt <= cnt - PWIDTH'(1);
      end
    end
  end

  assign bus.dv_out  = vld_p0;
  assign bus.d_out   = sample_p0;
  assign bus.seq_out = seq_p0;
endmodule

// File: tb/tb_adc_emulator_multi.sv
// Directed bench for adc_emulator_multi with hand-computed expected samples.
module tb_adc_emulator_multi;
  localparam int NCHAN = 4, DWIDTH = 18, AWIDTH = 10, PWIDTH = 8, CHAN_OFFSET = 256;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  adc_emulator_multi_if #(.NCHAN(NCHAN), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .PWIDTH(PWIDTH)) bus ();

  adc_emulator_multi #(
    .NCHAN(NCHAN), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .PWIDTH(PWIDTH), .CHAN_OFFSET(CHAN_OFFSET)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ch(input int c);
    logic signed [DWIDTH-1:0] v;
    v = bus.d_out[c];
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input int maxc, output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!bus.dv_out && gap < maxc);
    check({tag, "_dv"}, longint'(bus.dv_out), 1);
  endtask

  task automatic run_to_seq(input string tag, input int target, input int maxc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.dv_out && int'(bus.seq_out) == target) && n < maxc);
    check(tag, longint'(bus.seq_out), target);
  endtask

  int gap, prev_seq, prev_d0, dv_seen;

  initial begin
    resetn        = 1'b0;
    bus.enable    = 1'b1;
    bus.period    = 8'd6;
    bus.phase_inc = 10'd1;
    bus.mode      = 2'd0;

    step();
    check("rst_dv", bus.dv_out, 0);
    check("rst_seq", bus.seq_out, 0);
    for (int c = 0; c < NCHAN; c++) check("rst_d", ch(c), 0);

    resetn = 1'b1;
    step();
    check("first_dv", bus.dv_out, 1);
    check("first_seq", bus.seq_out, 0);
    check("sin0_ch0", ch(0), 0);
    check("sin0_ch1", ch(1), 131071);
    check("sin0_ch2", ch(2), 0);
    check("sin0_ch3", ch(3), -131071);

    bus.period = 8'd2;
    wait_strobe("s1", 20, gap);
    check("gap_old_period", gap, 7);
    check("s1_seq", bus.seq_out, 1);
    check("sin1_ch0", ch(0), 804);
    wait_strobe("s2", 20, gap);
    check("gap_new_period", gap, 3);
    check("s2_seq", bus.seq_out, 2);
    wait_strobe("s3", 20, gap);
    check("gap_new_period2", gap, 3);

    bus.period = 8'd0;
    run_to_seq("to128", 128, 400);
    check("sin128_ch0", ch(0), 92681);
    run_to_seq("to256", 256, 400);
    check("sin256_ch0", ch(0), 131071);
    check("sin256_ch1", ch(1), 0);
    check("sin256_ch2", ch(2), -131071);
    for (int i = 0; i < 3; i++) begin
      step();
      check("cont_dv", bus.dv_out, 1);
    end

    resetn = 1'b0;
    step();
    check("rst2_seq", bus.seq_out, 0);
    check("rst2_d0", ch(0), 0);
    resetn        = 1'b1;
    bus.mode      = 2'd1;
    bus.phase_inc = 10'd1;
    run_to_seq("to1022", 1022, 1100);
    check("ramp1022_ch0", ch(0), -512);
    bus.phase_inc = 10'd3;
    step();
    check("ramp1023_seq", bus.seq_out, 1023);
    check("ramp1023_ch0", ch(0), -256);
    check("ramp1023_ch1", ch(1), 65280);
    step();
    check("ramp_wrap_ch0", ch(0), 512);
    check("ramp_wrap_ch3", ch(3), -65024);
    step();
    check("ramp5_ch0", ch(0), 1280);

    bus.mode   = 2'd2;
    bus.period = 8'd6;
    step();
    check("id_dv", bus.dv_out, 1);
    for (int c = 0; c < NCHAN; c++) check("id_a", ch(c), c + 1);
    wait_strobe("id2", 20, gap);
    check("id_gap", gap, 7);
    for (int c = 0; c < NCHAN; c++) check("id_b", ch(c), c + 1);
    prev_seq = int'(bus.seq_out);
    for (int i = 0; i < 3; i++) step();
    bus.mode = 2'd3;
    wait_strobe("seqm", 20, gap);
    check("seqm_gap", gap, 4);
    check("seqm_seq", bus.seq_out, prev_seq + 1);
    for (int c = 0; c < NCHAN; c++) check("seqm_d", ch(c), prev_seq + 1 + c);

    prev_seq = int'(bus.seq_out);
    prev_d0  = ch(0);
    for (int i = 0; i < 3; i++) step();
    bus.enable = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dv_out) dv_seen++;
    end
    check("gap_dv_count", dv_seen, 0);
    check("gap_seq_hold", bus.seq_out, prev_seq);
    check("gap_d0_hold", ch(0), prev_d0);
    bus.enable = 1'b1;
    wait_strobe("resume", 20, gap);
    check("resume_gap", gap, 4);
    check("resume_seq", bus.seq_out, prev_seq + 1);
    check("resume_d0", ch(0), prev_seq + 1);

    step();
    step();
    resetn = 1'b0;
    step();
    check("rst3_dv", bus.dv_out, 0);
    check("rst3_seq", bus.seq_out, 0);
    check("rst3_d3", ch(3), 0);
    resetn = 1'b1;
    step();
    check("rel_dv", bus.dv_out, 1);
    check("rel_seq", bus.seq_out, 0);
    for (int c = 0; c < NCHAN; c++) check("rel_d", ch(c), c);

    bus.period = 8'd0;
    run_to_seq("to65535", 65535, 70000);
    check("wrap_pre_ch0", ch(0), 65535);
    check("wrap_pre_ch1", ch(1), 65536);
    step();
    check("wrap_seq", bus.seq_out, 0);
    check("wrap_ch0", ch(0), 0);
    check("wrap_ch3", ch(3), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_emulator_multi.md
# adc_emulator_multi

Parametrised multi-channel ADC emulator that replaces the fixed 4-channel, 18-bit, 1/7-rate sine source. It produces a periodic data-valid strobe with NCHAN parallel samples in one of four runtime-selectable patterns: phase-offset sine, ramp, channel ID or sequence count. Sample rate and tone frequency are runtime-programmable. It sits upstream of the AXI-stream packer and lets the DDR capture path be exercised and checked without real converter hardware.

## Interface
- NCHAN, 4, number of output channels (1..16)
- DWIDTH, 18, sample width, two's complement (DWIDTH >= AWIDTH)
- AWIDTH, 10, phase accumulator / sine ROM address width; ROM depth 2^AWIDTH
- PWIDTH, 8, width of period input
- CHAN_OFFSET, 200, phase offset between adjacent channels, in ROM entries
- clk  in  1  sole clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  1 = run; 0 = freeze all state
- period  in  PWIDTH  dv_out fires every period+1 enabled cycles
- phase_inc  in  AWIDTH  phase advance per emitted sample
- mode  in  2  0 sine, 1 ramp, 2 channel ID, 3 sequence count
- dv_out  out  1  one-cycle sample strobe
- d_out  out  NCHAN x DWIDTH  packed samples, channel c at d_out[c]
- seq_out  out  16  index of the current sample, valid with dv_out

## Operation
- State: down-counter cnt[PWIDTH], phase accumulator addr[AWIDTH], sample counter seq[16].
- Fire condition: enable=1 and cnt==0. On fire:
  - cnt <= period
  - addr <= addr + phase_inc (mod 2^AWIDTH)
  - seq <= seq + 1 (wraps 65535->0)
  - dv_out <= 1; seq_out <= seq
  - d_out computed from the pre-increment addr/seq and the current mode.
- enable=1 and cnt!=0: cnt <= cnt-1, dv_out <= 0.
- enable=0: cnt, addr, seq, d_out, seq_out hold; dv_out <= 0.
- Channel address: a_c = (addr + c*CHAN_OFFSET) mod 2^AWIDTH.
- Mode 0: d_out[c] = ROM[a_c]. ROM[i] = round-half-away-from-zero((2^(DWIDTH-1)-1)*sin(2*pi*i/2^AWIDTH)), built at elaboration. Range is symmetric; -2^(DWIDTH-1) never appears.
- Mode 1: d_out[c] = a_c << (DWIDTH-AWIDTH), zero-filled LSBs, MSB is the raw sign bit (sawtooth).
- Mode 2: d_out[c] = c+1, zero-extended.
- Mode 3: d_out[c] = (seq + c) mod 2^DWIDTH, from seq zero-extended.
- period, phase_inc and mode are sampled only at fire. A change mid-interval affects the next fire: the new period governs the following reload, and the new mode/phase_inc apply to the next emitted sample.
- d_out holds its last value between strobes.

## Timing
- Reset (resetn=0 at an edge): dv_out=0, d_out=all 0, seq_out=0, cnt=0, addr=0, seq=0. Reset overrides enable and any fire in the same cycle.
- After reset release with enable=1, the first dv_out is at the first enabled edge: cnt=0, so it fires immediately. That strobe carries seq_out=0 and addr=0 data.
- Strobe spacing is exactly period+1 enabled cycles; period=0 gives dv_out continuously high.
- Latency: outputs are registered, one edge after the fire condition. d_out, seq_out and dv_out are always mutually aligned. A ROM implementation must keep this alignment.
- Reset mid-interval discards partial count; no strobe is emitted in the reset cycle or in the edge that applies reset.

## Test plan
- Reset, enable=1, period=6, phase_inc=1, mode=0, CHAN_OFFSET=256 -> dv_out pulses every 7 cycles, first on edge 1. Sample 0: d_out = {0, 131071, 0, -131071} for ch0..3. Sample 256: ch0=131071. seq_out increments 0,1,2…
- period=0, phase_inc=3, addr preloaded to 1022 by running 1022/3-aligned steps, mode=1 -> dv_out high every cycle; addr wraps 1023->2 correctly; ramp ch0 = addr<<8.
- mode=2, NCHAN=4 -> d_out = {1,2,3,4} on every strobe. Switch to mode=3 mid-interval -> the next strobe (not earlier) shows seq, seq+1, seq+2, seq+3.
- enable dropped 3 cycles into a period=6 interval for 10 cycles, then raised -> no dv_out while low; next strobe lands 4 enabled cycles later; d_out and seq unchanged across the gap.
- Change period 6->2 immediately after a strobe -> the next gap is still 7 cycles, then 3-cycle gaps follow.
- resetn low for one cycle mid-interval, then high -> outputs zero the following edge; the next strobe fires on the first enabled edge after release with seq_out=0 and addr=0 data. Run seq past 65535 -> wraps to 0.
